// File: rtl/snn_pkg.sv
// Shared definitions for the SNN LIF sweep engine: bank bases, state-word
// field layout, FSM encoding and the per-neuron address helper.
package snn_pkg;

  // Byte address of neuron 0 in the neuron-state and forward (current) banks.
  localparam logic [15:0] STATE_BASE = 16'hE000;
  localparam logic [15:0] CUR_BASE   = 16'h1000;

  // State word layout: [15:0] signed v, [23:16] refractory count, [31:24] zero.
  localparam int V_LSB = 0;
  localparam int V_W   = 16;
  localparam int R_LSB = 16;
  localparam int R_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRA  = 3'd1,
    S_SRD  = 3'd2,
    S_CRA  = 3'd3,
    S_CRD  = 3'd4,
    S_CALC = 3'd5,
    S_WR   = 3'd6,
    S_SPK  = 3'd7
  } lif_state_e;

  // Word-per-neuron addressing: base + 4*idx.
  function automatic logic [15:0] neuron_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {6'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/snn_lif_alu.sv
// Combinational leaky integrate-and-fire update for a single neuron.
module snn_lif_alu
  import snn_pkg::*;
#(
  parameter int                 LEAK_SHIFT = 4,
  parameter logic signed [15:0] THRESH     = 16'sd4096,
  parameter logic signed [15:0] V_RESET    = 16'sd0,
  parameter logic [7:0]         REFRAC     = 8'd2
) (
  input  logic signed [V_W-1:0] v_i,
  input  logic        [R_W-1:0] r_i,
  input  logic signed [V_W-1:0] cur_i,
  output logic signed [V_W-1:0] v_o,
  output logic        [R_W-1:0] r_o,
  output logic                  spike_o
);

  logic signed [17:0] v_ext;
  logic signed [17:0] cur_ext;
  logic signed [17:0] sum;
  logic signed [15:0] sat;

  // Leak + integrate at 18 bits so the worst-case sum cannot wrap, then clamp.
  always_comb begin
    v_ext   = $signed({{2{v_i[15]}}, v_i});
    cur_ext = $signed({{2{cur_i[15]}}, cur_i});
    sum     = v_ext - (v_ext >>> LEAK_SHIFT) + cur_ext;
    if (sum > 18'sd32767) begin
      sat = 16'sh7FFF;
    end else if (sum < -18'sd32768) begin
      sat = 16'sh8000;
    end else begin
      sat = sum[15:0];
    end
  end

  // Refractory neurons sit at reset and count down; others fire on threshold.
  always_comb begin
    v_o     = V_RESET;
    r_o     = 8'd0;
    spike_o = 1'b0;
    if (r_i != 8'd0) begin
      v_o     = V_RESET;
      r_o     = r_i - 8'd1;
      spike_o = 1'b0;
    end else if (sat >= THRESH) begin
      v_o     = V_RESET;
      r_o     = REFRAC;
      spike_o = 1'b1;
    end else begin
      v_o     = sat;
      r_o     = 8'd0;
      spike_o = 1'b0;
    end
  end

endmodule

// File: rtl/snn_lif_sweep.sv
// LIF sweep engine: reads state and current for every neuron over the
// single-port memory bus, updates it, writes it back and emits spikes.
// All outputs are decoded from registers only.
module snn_lif_sweep #(
  parameter int                 N_NEURONS  = 256,
  parameter int                 LEAK_SHIFT = 4,
  parameter logic signed [15:0] THRESH     = 16'sd4096,
  parameter logic signed [15:0] V_RESET    = 16'sd0,
  parameter logic [7:0]         REFRAC     = 8'd2,
  parameter logic [15:0]        STATE_BASE = snn_pkg::STATE_BASE,
  parameter logic [15:0]        CUR_BASE   = snn_pkg::CUR_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] spike_count,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic [7:0]  spike_idx
);

  import snn_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(N_NEURONS - 1);

  lif_state_e         state_q, state_d;
  logic [7:0]         idx_q, idx_d;
  logic signed [15:0] v_q, v_d;
  logic [7:0]         r_q, r_d;
  logic signed [15:0] cur_q, cur_d;
  logic signed [15:0] v_new_q, v_new_d;
  logic [7:0]         r_new_q, r_new_d;
  logic               spike_q, spike_d;
  logic               done_q, done_d;
  logic [15:0]        spike_count_q, spike_count_d;

  logic signed [15:0] alu_v;
  logic [7:0]         alu_r;
  logic               alu_spike;
  logic               last_neuron;
  logic               unused_rdata;

  // The top byte of the state word is always rewritten as zero.
  assign unused_rdata = ^mem_rdata[31:24];
  assign last_neuron  = (idx_q == LAST_IDX);

  snn_lif_alu #(
    .LEAK_SHIFT (LEAK_SHIFT),
    .THRESH     (THRESH),
    .V_RESET    (V_RESET),
    .REFRAC     (REFRAC)
  ) u_alu (
    .v_i     (v_q),
    .r_i     (r_q),
    .cur_i   (cur_q),
    .v_o     (alu_v),
    .r_o     (alu_r),
    .spike_o (alu_spike)
  );

  // State and datapath registers; reset abandons any in-flight neuron.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 8'd0;
      v_q           <= 16'sd0;
      r_q           <= 8'd0;
      cur_q         <= 16'sd0;
      v_new_q       <= 16'sd0;
      r_new_q       <= 8'd0;
      spike_q       <= 1'b0;
      done_q        <= 1'b0;
      spike_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      v_q           <= v_d;
      r_q           <= r_d;
      cur_q         <= cur_d;
      v_new_q       <= v_new_d;
      r_new_q       <= r_new_d;
      spike_q       <= spike_d;
      done_q        <= done_d;
      spike_count_q <= spike_count_d;
    end
  end

  // Next-state logic: one neuron is SRA..WR (plus SPK when it fires).
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    v_d           = v_q;
    r_d           = r_q;
    cur_d         = cur_q;
    v_new_d       = v_new_q;
    r_new_d       = r_new_q;
    spike_d       = spike_q;
    done_d        = 1'b0;
    spike_count_d = spike_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_SRA;
          idx_d         = 8'd0;
          spike_count_d = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SRA: state_d = S_SRD;
      S_SRD: begin
        v_d     = mem_rdata[V_LSB +: V_W];
        r_d     = mem_rdata[R_LSB +: R_W];
        state_d = S_CRA;
      end
      S_CRA: state_d = S_CRD;
      S_CRD: begin
        cur_d   = mem_rdata[15:0];
        state_d = S_CALC;
      end
      S_CALC: begin
        v_new_d = alu_v;
        r_new_d = alu_r;
        spike_d = alu_spike;
        state_d = S_WR;
      end
      S_WR: begin
        if (spike_q) begin
          state_d = S_SPK;
        end else if (last_neuron) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_SRA;
        end
      end
      S_SPK: begin
        if (spike_ready) begin
          if (spike_count_q != 16'hFFFF) begin
            spike_count_d = spike_count_q + 16'd1;
          end else begin
            spike_count_d = spike_count_q;
          end
          if (last_neuron) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_SRA;
          end
        end else begin
          state_d = S_SPK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; address is held through capture cycles.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    spike_count = spike_count_q;
    mem_we      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 32'h0000_0000;
    spike_valid = 1'b0;
    spike_idx   = 8'h00;
    case (state_q)
      S_SRA, S_SRD: mem_addr = neuron_addr(STATE_BASE, idx_q);
      S_CRA, S_CRD: mem_addr = neuron_addr(CUR_BASE, idx_q);
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = neuron_addr(STATE_BASE, idx_q);
        mem_wdata = {8'h00, r_new_q, v_new_q};
      end
      S_SPK: begin
        spike_valid = 1'b1;
        spike_idx   = idx_q;
      end
      default: mem_addr = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_snn_lif_sweep.sv
// Self-checking bench for snn_lif_sweep with a BRAM-style memory model and
// an arithmetic reference of the LIF rules.
module tb_snn_lif_sweep;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, mem_we, spike_valid, spike_ready;
  logic [15:0] spike_count, mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  spike_idx;

  logic [31:0] smem [NN];
  logic [31:0] cmem [NN];
  logic [31:0] ref_state [NN];
  logic        ld_en;
  int          ld_idx;
  logic [31:0] ld_data;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_count;
  bit          have_last = 0;

  always #5 clk = ~clk;

  snn_lif_sweep #(
    .N_NEURONS(NN), .LEAK_SHIFT(4), .THRESH(16'sd4096), .V_RESET(16'sd0),
    .REFRAC(8'd2), .STATE_BASE(16'hE000), .CUR_BASE(16'h1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .spike_count(spike_count), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_idx(spike_idx)
  );

  function automatic int bank_index(input logic [15:0] a, input logic [15:0] base);
    int off;
    off = int'(a) - int'(base);
    if (off < 0 || off >= 4 * NN || a[1:0] != 2'b00) return -1;
    return off / 4;
  endfunction

  // One-cycle-latency memory; bench loads share the write port.
  always @(posedge clk) begin
    if (bank_index(mem_addr, 16'hE000) >= 0) mem_rdata <= smem[bank_index(mem_addr, 16'hE000)];
    else if (bank_index(mem_addr, 16'h1000) >= 0) mem_rdata <= cmem[bank_index(mem_addr, 16'h1000)];
    else mem_rdata <= 32'hDEAD_BEEF;
    if (ld_en) smem[ld_idx] <= ld_data;
    else if (mem_we && bank_index(mem_addr, 16'hE000) >= 0) smem[bank_index(mem_addr, 16'hE000)] <= mem_wdata;
  end

  // Reference LIF rule written as plain integer arithmetic.
  function automatic void lif_ref(input logic [31:0] st, input logic [31:0] cu,
                                  output logic [31:0] nst, output bit spk);
    int v, r, i, s, leak;
    v = $signed(st[15:0]);
    r = int'(st[23:16]);
    i = $signed(cu[15:0]);
    spk = 0;
    if (r != 0) begin
      nst = {8'h00, 8'(r - 1), 16'h0000};
    end else begin
      leak = (v >= 0) ? v / 16 : -((-v + 15) / 16);
      s = v - leak + i;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (s >= 4096) begin
        spk = 1;
        nst = {8'h00, 8'd2, 16'h0000};
      end else begin
        nst = {16'h0000, 16'(s)};
      end
    end
  endfunction

  task automatic load(input int n, input int v, input int r, input int i, input logic [7:0] junk);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = n; ld_data = {junk, 8'(r), 16'(v)};
    ref_state[n] = {8'h00, 8'(r), 16'(v)};
    ref_state[n][31:24] = junk;
    cmem[n] = {~junk, junk, 16'(i)};
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Runs one sweep; fixed_hold >= 0 stalls every spike that long, else random.
  task automatic run_sweep(input string tag, input int fixed_hold, input bit poke_start);
    logic [31:0] exp_wr[$];
    int exp_spk[$];
    int holds[$];
    logic [31:0] nst;
    bit spk, got_done;
    int n_spk, wait_total, exp_done, cyc, wr_n, wcnt, h;
    n_spk = 0; wait_total = 0; wr_n = 0; wcnt = 0; got_done = 0;
    for (int n = 0; n < NN; n++) begin
      lif_ref(ref_state[n], cmem[n], nst, spk);
      exp_wr.push_back(nst);
      if (spk) begin
        h = (fixed_hold >= 0) ? fixed_hold : int'($urandom_range(0, 3));
        exp_spk.push_back(n); holds.push_back(h);
        wait_total += h; n_spk++;
      end
      ref_state[n] = nst;
    end
    exp_done = 1 + 6 * NN + n_spk + wait_total;
    @(negedge clk);
    if (have_last) begin
      vectors++;
      if (spike_count !== last_count) begin
        miscompares++;
        $display("FAIL %s count_stable: got %0d want %0d", tag, spike_count, last_count);
      end
    end
    start = 1'b1; spike_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!got_done && cyc < 2000) begin
      if (poke_start) start = (cyc == 3);
      if (mem_we) begin
        vectors++;
        if (wr_n >= NN || mem_addr !== 16'hE000 + 16'(4 * wr_n) || mem_wdata !== exp_wr[wr_n]) begin
          miscompares++;
          $display("FAIL %s write%0d: got addr %h data %h want addr %h data %h", tag, wr_n,
                   mem_addr, mem_wdata, 16'hE000 + 16'(4 * wr_n), (wr_n < NN) ? exp_wr[wr_n] : 32'h0);
        end
        wr_n++;
      end
      if (spike_valid) begin
        vectors++;
        if (exp_spk.size() == 0) begin
          miscompares++;
          $display("FAIL %s spike_unexpected: got idx %0d want none", tag, spike_idx);
          spike_ready = 1'b1;
        end else begin
          if (spike_idx !== 8'(exp_spk[0]) || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL %s spike_idx: got %0d we %b want %0d we 0", tag, spike_idx, mem_we, exp_spk[0]);
          end
          if (wcnt < holds[0]) begin
            spike_ready = 1'b0; wcnt++;
          end else begin
            spike_ready = 1'b1; wcnt = 0;
            void'(exp_spk.pop_front()); void'(holds.pop_front());
          end
        end
      end else begin
        spike_ready = 1'($urandom_range(0, 1));
      end
      vectors++;
      if (done) begin
        got_done = 1;
        if (cyc != exp_done || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s done_timing: got cycle %0d busy %b want cycle %0d busy 0", tag, cyc, busy, exp_done);
        end
      end else if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy: got %b want 1 at cycle %0d", tag, busy, cyc);
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; spike_ready = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL %s timeout: got no done want done at cycle %0d", tag, exp_done);
    end
    vectors++;
    if (wr_n != NN || exp_spk.size() != 0 || spike_count !== 16'(n_spk)) begin
      miscompares++;
      $display("FAIL %s totals: got writes %0d left %0d count %0d want %0d 0 %0d",
               tag, wr_n, exp_spk.size(), spike_count, NN, n_spk);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || spike_count !== 16'(n_spk)) begin
      miscompares++;
      $display("FAIL %s done_pulse: got done %b count %0d want 0 %0d", tag, done, spike_count, n_spk);
    end
    for (int n = 0; n < NN; n++) begin
      vectors++;
      if (smem[n] !== ref_state[n]) begin
        miscompares++;
        $display("FAIL %s mem%0d: got %h want %h", tag, n, smem[n], ref_state[n]);
      end
    end
    last_count = 16'(n_spk); have_last = 1;
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || spike_count !== 16'd0 || mem_we !== 1'b0 ||
        mem_addr !== 16'd0 || mem_wdata !== 32'd0 || spike_valid !== 1'b0 || spike_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL %s outputs: got busy %b done %b cnt %h we %b addr %h wd %h sv %b idx %h want all 0",
               tag, busy, done, spike_count, mem_we, mem_addr, mem_wdata, spike_valid, spike_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; spike_ready = 1'b0; ld_en = 1'b0; ld_idx = 0; ld_data = 32'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_no_spike();
    load(0, 4000, 0, 200, 8'hA5);
    load(1, -32768, 0, -32768, 8'h00);
    load(2, 999, 2, 5000, 8'h3C);
    load(3, 100, 0, -50, 8'hFF);
    run_sweep("no_spike", 0, 0);
    vectors++;
    if (smem[0] !== 32'h0000_0F6E || smem[1] !== 32'h0000_8000 || smem[2] !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL no_spike_words: got %h %h %h want 00000f6e 00008000 00010000", smem[0], smem[1], smem[2]);
    end
    run_sweep("refrac_r1", 0, 0);
    vectors++;
    if (smem[2] !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL refrac_r0: got %h want 00000000", smem[2]);
    end
  endtask

  task automatic test_spike_hold();
    load(0, 4096, 0, 300, 8'h11);
    load(1, 0, 0, 0, 8'h22);
    load(2, 32000, 0, 32767, 8'h33);
    load(3, 10, 0, 1, 8'h44);
    run_sweep("spike_hold", 5, 0);
    vectors++;
    if (smem[0] !== 32'h0002_0000 || smem[2] !== 32'h0002_0000 || spike_count !== 16'd2) begin
      miscompares++;
      $display("FAIL spike_words: got %h %h cnt %0d want 00020000 00020000 2", smem[0], smem[2], spike_count);
    end
  endtask

  task automatic test_random();
    int v, r, i;
    for (int s = 0; s < 8; s++) begin
      for (int n = 0; n < NN; n++) begin
        if ($urandom_range(0, 1) == 0) begin
          v = int'($urandom_range(3700, 4500)); i = int'($urandom_range(0, 600)) - 300;
        end else begin
          v = $signed(16'($urandom)); i = $signed(16'($urandom));
        end
        r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        load(n, v, r, i, 8'($urandom));
      end
      run_sweep($sformatf("random%0d", s), -1, (s % 2) == 1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] old [NN];
    logic [31:0] n0;
    bit spk;
    load(0, 100, 0, 10, 8'h00);
    load(1, 200, 0, 20, 8'h00);
    load(2, 300, 0, 30, 8'h00);
    load(3, 400, 0, 40, 8'h00);
    for (int n = 0; n < NN; n++) old[n] = ref_state[n];
    lif_ref(old[0], cmem[0], n0, spk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    check_outputs_zero("mid_reset_held");
    vectors++;
    if (smem[0] !== n0 || smem[1] !== old[1] || smem[2] !== old[2] || smem[3] !== old[3]) begin
      miscompares++;
      $display("FAIL mid_reset_mem: got %h %h %h %h want %h %h %h %h",
               smem[0], smem[1], smem[2], smem[3], n0, old[1], old[2], old[3]);
    end
    rst = 1'b0;
    ref_state[0] = n0;
    have_last = 0;
    @(negedge clk);
    run_sweep("after_reset", 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_no_spike();
    test_spike_hold();
    test_random();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_lif_sweep.md
# snn_lif_sweep

Leaky integrate-and-fire update engine for the SNN accelerator. On each `start` it sweeps all neurons once. For each neuron it:
- reads the neuron state word from the neuron-state bank (0xE000) and the input-current word from the forward bank (0x1000) through the SNN memory controller's single-port bus;
- applies leak, integration, threshold and refractory rules;
- writes the state back;
- emits a spike event downstream with a valid/ready handshake.

It sits directly upstream of the memory controller and is a bus master on it.

## Interface
Parameters:
- `N_NEURONS`, 256: neurons per sweep (1..256).
- `LEAK_SHIFT`, 4: leak = v >>> LEAK_SHIFT.
- `THRESH`, 16'sd4096: spike threshold, signed.
- `V_RESET`, 16'sd0: post-spike membrane value.
- `REFRAC`, 8'd2: refractory sweeps after a spike.
- `STATE_BASE`, 16'hE000: byte address of neuron 0 state.
- `CUR_BASE`, 16'h1000: byte address of neuron 0 current.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin sweep; sampled only in IDLE.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep end.
- `spike_count` out 16: spikes in the last sweep; stable from `done` until the next `start`.
- `mem_we` out 1: write strobe to the memory controller.
- `mem_addr` out 16: byte address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data (one-cycle BRAM latency).
- `spike_valid` out 1: spike event valid.
- `spike_ready` in 1: downstream accepts.
- `spike_idx` out 8: index of the spiking neuron.

## Operation
Word formats:
- State word: [15:0] signed membrane v; [23:16] refractory count r; [31:24] written as 0.
- Current word: [15:0] signed I; [31:16] ignored.
- Neuron i uses address STATE_BASE+4i for its state and CUR_BASE+4i for its current.

FSM states: IDLE, SRA, SRD, CRA, CRD, CALC, WR, SPK.
- IDLE: `start`=1 -> SRA, with i=0 and `spike_count`=0.
- SRA: `mem_addr`=state address of neuron i. -> SRD.
- SRD: address held; capture `mem_rdata` into the state register. -> CRA.
- CRA: `mem_addr`=current address of neuron i. -> CRD.
- CRD: address held; capture I. -> CALC.
- CALC: compute the new state (rules below). -> WR.
- WR: `mem_we`=1, `mem_addr`=state address, `mem_wdata`={8'h0, r', v'}.
  - If a spike occurred -> SPK.
  - Else if i = N_NEURONS-1 -> IDLE with `done`.
  - Else i+1 -> SRA.
- SPK: `spike_valid`=1, `spike_idx`=i.
  - Leave only when `spike_ready`=1; then go to the next neuron or finish, same rule as WR.
  - `spike_count` increments on acceptance.

Update rules:
- r != 0: v'=V_RESET, r'=r-1, I ignored, no spike.
- r = 0:
  - s = v - (v >>> LEAK_SHIFT) + I, computed at 18 bits signed.
  - Saturate s to [-32768, 32767] to get v.
  - If v >= THRESH: spike, v'=V_RESET, r'=REFRAC.
  - Otherwise v'=v, r'=0.

Control rules:
- `mem_we` is 1 only in WR; `mem_addr`/`mem_wdata` are 0 in IDLE.
- `start` while busy is ignored.
- `spike_count` saturates at 16'hFFFF.

## Timing
- Reset: all outputs are 0, FSM goes to IDLE, i=0; no bus write is issued.
- Reset mid-sweep aborts immediately. A partially updated neuron is not written, so memory holds either old or fully updated state for every neuron.
- Bus outputs, `spike_*`, `busy` and `done` are decoded from registered state only; there is no combinational path from any input to any output.
- Memory reads: the address is presented in SRA/CRA and held the next cycle; rdata is sampled at the end of SRD/CRD. Because the controller's read mux keys on the current address, the address must not change during the capture cycle.
- Per neuron: 6 cycles without a spike, 7+k cycles with a spike, where k is the number of cycles spent waiting on ready.
- Start sampled at edge 0: `busy` is high from cycle 1.
- With no spikes: `done` is high and `busy` is low at cycle 6N+1.
- `spike_valid` stays asserted and `spike_idx` stays stable until accepted.

## Structure
- Shared package `snn_pkg` holds:
  - bank base constants (STATE_BASE, CUR_BASE);
  - the state-word field offsets;
  - the FSM state enum.
- One sub-module, `snn_lif_alu`: purely combinational; inputs v, r, I; outputs v', r', spike.

## Test plan
- N=1, v=4000, r=0, I=200 -> write 0x00000F6E (v=3950); no spike; `done` at cycle 7.
- v=4096, I=300 -> s=4140, spike idx 0; write 0x00020000; `spike_count`=1.
- v=32000, I=32767 -> saturates to 32767 and spikes; v=-32768, I=-32768 -> v'=-32768 (0x00008000), no spike.
- r=2, v=999, I=5000 -> write 0x00010000; no spike. Re-sweep -> r=1, then r=0.
- N=4, neuron 2 spikes, `spike_ready` low for 5 cycles -> `spike_valid` held, `spike_idx`=2, no bus activity; then finish with `spike_count`=1.
- Assert `rst` during CALC of neuron 1 -> no WR for neuron 1, neuron 0 is updated, outputs are 0; a new `start` repeats the full sweep.
